// File: rtl/rom_ctrl_pkg.sv
// rtl/rom_ctrl_pkg.sv - shared types and sizing for the ROM frame reader
package rom_ctrl_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rom_frame_reader_if.sv
// rtl/rom_frame_reader_if.sv - output word stream between frame reader and consumer
interface rom_frame_reader_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/sync_fifo2.sv
// rtl/sync_fifo2.sv - 2-entry synchronous skid FIFO with flush
module sync_fifo2
  import rom_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is allowed only when the head leaves the same cycle.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/rom_frame_reader.sv
// rtl/rom_frame_reader.sv - reads a run of ROM words and streams them out
// through a 2-entry skid buffer that absorbs ROM latency and back-pressure.
module rom_frame_reader
  import rom_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_sig,
  input  logic                     abort_sig,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W-1:0]        len_m1,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  rom_frame_reader_if.master       strm,
  output logic                     busy_sig,
  output logic                     done_sig
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] issue_cnt;
  logic [ADDR_W-1:0] beat_cnt;
  logic              rd_pend;

  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              pop;
  logic              accept;
  logic              issue;
  logic              flush;
  logic              room;

  assign pop = strm.out_valid && strm.out_ready;

  // Words held plus word in flight, after this cycle's pop, must stay below two.
  assign room = ({1'b0, fifo_count} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop});

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        if (start_sig && !abort_sig) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        if (abort_sig) begin
          flush      = 1'b1;
          state_next = IDLE;
        end else if (room) begin
          issue = 1'b1;
          if (issue_cnt == len_q) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort_sig) begin
          flush      = 1'b1;
          state_next = IDLE;
        end else if (pop && (beat_cnt == len_q)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        flush      = abort_sig;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      last_addr <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      rd_pend   <= 1'b0;
    end else begin
      state   <= state_next;
      rd_pend <= issue;
      if (accept) begin
        addr_q    <= start_addr;
        len_q     <= len_m1;
        issue_cnt <= '0;
        beat_cnt  <= '0;
      end else begin
        if (issue) begin
          addr_q    <= addr_q + ADDR_W'(1);
          last_addr <= addr_q;
          issue_cnt <= issue_cnt + ADDR_W'(1);
        end
        if (pop && ((state == READ) || (state == DRAIN))) begin
          beat_cnt <= beat_cnt + ADDR_W'(1);
        end
      end
    end
  end

  // The ROM sees the new address only on issue cycles; otherwise it re-reads the last one.
  assign rom_addr = issue ? addr_q : last_addr;

  sync_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend),
    .pop       (pop),
    .flush     (flush),
    .push_data (rom_data),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign strm.out_valid = (fifo_count != 2'd0);
  assign strm.out_data  = fifo_head;
  assign busy_sig       = (state != IDLE);
  assign done_sig       = (state == DONE);

endmodule

// File: tb/tb_rom_frame_reader.sv
// tb/tb_rom_frame_reader.sv - directed self-checking bench for rom_frame_reader
module tb_rom_frame_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_sig;
  logic       abort_sig;
  logic [3:0] start_addr;
  logic [3:0] len_m1;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       busy_sig;
  logic       done_sig;

  rom_frame_reader_if #(.DATA_W(8)) strm ();

  rom_frame_reader #(
    .ADDR_W (4),
    .DATA_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_sig  (start_sig),
    .abort_sig  (abort_sig),
    .start_addr (start_addr),
    .len_m1     (len_m1),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .strm       (strm),
    .busy_sig   (busy_sig),
    .done_sig   (done_sig)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  logic [7:0] beat_q[$];
  int         beat_cyc[$];
  int         done_cyc[$];

  function automatic logic [7:0] rom_word(input logic [3:0] a);
    if (a == 4'd0) return 8'h5a;
    if (a == 4'd15) return 8'h6b;
    return 8'h7e;
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  // Records every handshake and done pulse with the cycle it happened in.
  always @(posedge clk) begin
    if (strm.out_valid && strm.out_ready) begin
      beat_q.push_back(strm.out_data);
      beat_cyc.push_back(cyc);
    end
    if (done_sig) done_cyc.push_back(cyc);
    cyc = cyc + 1;
  end

  task automatic start_frame(input logic [3:0] sa, input logic [3:0] lm);
    @(negedge clk);
    beat_q.delete();
    beat_cyc.delete();
    done_cyc.delete();
    start_sig  = 1'b1;
    start_addr = sa;
    len_m1     = lm;
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    @(negedge clk);
    start_sig = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - t0 < n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_sig = 1'b0;
    abort_sig = 1'b0;
    start_addr = 4'd0;
    len_m1 = 4'd0;
    strm.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (strm.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", strm.out_valid); end
    total++; if (busy_sig !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_sig); end
    total++; if (done_sig !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_sig); end
    total++; if (rom_addr !== 4'd0) begin bad++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
    total++; if (strm.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", strm.out_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_frame(input bit poke_start);
    logic [7:0] exp_d;
    start_frame(4'd0, 4'd15);
    if (poke_start) begin
      wait_rel(5);
      start_sig = 1'b1;
      start_addr = 4'd7;
      len_m1 = 4'd2;
      @(negedge clk);
      start_sig = 1'b0;
    end
    wait_rel(19);
    total++; if (busy_sig !== 1'b1) begin bad++; $display("FAIL full_busy_c19 got=%b exp=1", busy_sig); end
    wait_rel(20);
    total++; if (busy_sig !== 1'b0) begin bad++; $display("FAIL full_busy_c20 got=%b exp=0", busy_sig); end
    wait_rel(23);
    total++; if (beat_q.size() != 16) begin bad++; $display("FAIL full_beat_count got=%0d exp=16", beat_q.size()); end
    for (int i = 0; i < 16 && i < beat_q.size(); i++) begin
      exp_d = (i == 0) ? 8'h5a : ((i == 15) ? 8'h6b : 8'h7e);
      total++; if (beat_q[i] !== exp_d) begin bad++; $display("FAIL full_beat_data[%0d] got=%h exp=%h", i, beat_q[i], exp_d); end
      total++; if (beat_cyc[i] - t0 != 3 + i) begin bad++; $display("FAIL full_beat_cycle[%0d] got=%0d exp=%0d", i, beat_cyc[i] - t0, 3 + i); end
    end
    total++; if (done_cyc.size() != 1) begin bad++; $display("FAIL full_done_count got=%0d exp=1", done_cyc.size()); end
    if (done_cyc.size() > 0) begin
      total++; if (done_cyc[0] - t0 != 19) begin bad++; $display("FAIL full_done_cycle got=%0d exp=19", done_cyc[0] - t0); end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_a [4];
    logic [7:0] exp_d [4];
    exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
    exp_d = '{8'h7e, 8'h6b, 8'h5a, 8'h7e};
    start_frame(4'd14, 4'd3);
    for (int r = 1; r <= 4; r++) begin
      wait_rel(r);
      total++; if (rom_addr !== exp_a[r-1]) begin bad++; $display("FAIL wrap_rom_addr[c%0d] got=%0d exp=%0d", r, rom_addr, exp_a[r-1]); end
    end
    wait_rel(10);
    total++; if (beat_q.size() != 4) begin bad++; $display("FAIL wrap_beat_count got=%0d exp=4", beat_q.size()); end
    for (int i = 0; i < 4 && i < beat_q.size(); i++) begin
      total++; if (beat_q[i] !== exp_d[i]) begin bad++; $display("FAIL wrap_beat_data[%0d] got=%h exp=%h", i, beat_q[i], exp_d[i]); end
    end
    total++; if (done_cyc.size() != 1 || done_cyc[0] - t0 != 7) begin bad++; $display("FAIL wrap_done got_count=%0d exp=1 at cycle 7", done_cyc.size()); end
  endtask

  task automatic test_back_pressure();
    bit         prev_stall;
    bit         rdy;
    logic [7:0] prev_data;
    logic [7:0] exp_d;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    start_frame(4'd0, 4'd15);
    for (int r = 1; r < 120 && done_cyc.size() == 0; r++) begin
      wait_rel(r);
      if (prev_stall) begin
        total++; if (strm.out_valid !== 1'b1 || strm.out_data !== prev_data) begin
          bad++; $display("FAIL bp_stable[c%0d] got=%b/%h exp=1/%h", r, strm.out_valid, strm.out_data, prev_data);
        end
      end
      total++; if (int'(dut.u_fifo.count) + int'(dut.rd_pend) > 2) begin
        bad++; $display("FAIL bp_occupancy[c%0d] got=%0d exp<=2", r, int'(dut.u_fifo.count) + int'(dut.rd_pend));
      end
      rdy = (r < 4) || (r > 9 && (r % 2) == 1);
      strm.out_ready = rdy;
      prev_stall = strm.out_valid && !rdy;
      prev_data  = strm.out_data;
    end
    @(negedge clk);
    strm.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (beat_q.size() != 16) begin bad++; $display("FAIL bp_beat_count got=%0d exp=16", beat_q.size()); end
    for (int i = 0; i < 16 && i < beat_q.size(); i++) begin
      exp_d = (i == 0) ? 8'h5a : ((i == 15) ? 8'h6b : 8'h7e);
      total++; if (beat_q[i] !== exp_d) begin bad++; $display("FAIL bp_beat_data[%0d] got=%h exp=%h", i, beat_q[i], exp_d); end
    end
    total++; if (done_cyc.size() != 1) begin bad++; $display("FAIL bp_done_count got=%0d exp=1", done_cyc.size()); end
  endtask

  task automatic test_abort();
    start_frame(4'd0, 4'd15);
    wait_rel(8);
    abort_sig = 1'b1;
    @(negedge clk);
    abort_sig = 1'b0;
    total++; if (strm.out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", strm.out_valid); end
    total++; if (busy_sig !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_sig); end
    repeat (4) @(negedge clk);
    total++; if (beat_q.size() != 6) begin bad++; $display("FAIL abort_beat_count got=%0d exp=6", beat_q.size()); end
    total++; if (done_cyc.size() != 0) begin bad++; $display("FAIL abort_done_count got=%0d exp=0", done_cyc.size()); end
    start_frame(4'd15, 4'd0);
    wait_rel(6);
    total++; if (beat_q.size() != 1) begin bad++; $display("FAIL single_beat_count got=%0d exp=1", beat_q.size()); end
    if (beat_q.size() > 0) begin
      total++; if (beat_q[0] !== 8'h6b || beat_cyc[0] - t0 != 3) begin
        bad++; $display("FAIL single_beat got=%h@%0d exp=6b@3", beat_q[0], beat_cyc[0] - t0);
      end
    end
    total++; if (done_cyc.size() != 1 || done_cyc[0] - t0 != 4) begin bad++; $display("FAIL single_done got_count=%0d exp=1 at cycle 4", done_cyc.size()); end
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    beat_q.delete();
    done_cyc.delete();
    start_sig  = 1'b1;
    abort_sig  = 1'b1;
    start_addr = 4'd3;
    len_m1     = 4'd2;
    @(negedge clk);
    start_sig = 1'b0;
    abort_sig = 1'b0;
    total++; if (busy_sig !== 1'b0) begin bad++; $display("FAIL start_abort_busy got=%b exp=0", busy_sig); end
    repeat (6) @(negedge clk);
    total++; if (beat_q.size() != 0 || done_cyc.size() != 0) begin
      bad++; $display("FAIL start_abort_activity got_beats=%0d got_done=%0d exp=0/0", beat_q.size(), done_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    start_frame(4'd0, 4'd15);
    wait_rel(6);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (strm.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", strm.out_valid); end
    total++; if (busy_sig !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy_sig); end
    total++; if (done_sig !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done_sig); end
    total++; if (rom_addr !== 4'd0) begin bad++; $display("FAIL rstmid_rom_addr got=%0d exp=0", rom_addr); end
    total++; if (strm.out_data !== 8'h00) begin bad++; $display("FAIL rstmid_out_data got=%h exp=00", strm.out_data); end
    @(negedge clk);
    test_full_frame(1'b0);
  endtask

  initial begin
    test_reset();
    test_full_frame(1'b0);
    test_wrap();
    test_back_pressure();
    test_abort();
    test_full_frame(1'b1);
    test_start_abort_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
